// File: rtl/err_compute_pkg.sv
// Shared types and constants for the line-follow error sequencer.
package err_compute_pkg;

  // Controller phases: wait for IR data, clear, accumulate, report.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } ec_state_t;

  // Operand select width; 8 operands (R0 L0 .. R3 L3).
  localparam int SEL_W = 3;

  // Select value of the final operand for a given number of R/L pairs.
  function automatic logic [SEL_W-1:0] last_sel(input int n_pairs);
    return SEL_W'(2 * n_pairs - 1);
  endfunction

endpackage

// File: rtl/err_compute_ctrl.sv
// Sequencer for the error accumulator: on IR_vld it clears the accumulator,
// steps sel through every R/L operand (even = add, odd = subtract) and then
// pulses err_vld. One extra start request can be queued while busy; a second
// one is dropped and flagged on the sticky ovr output.
//
// Handshake: IR_vld is a single-cycle request with no ready; it is always
// accepted (started, queued in pend, or dropped with ovr) in the cycle it is
// high. err_vld is a single-cycle qualifier for the accumulator value.
module err_compute_ctrl
  import err_compute_pkg::*;
#(
  parameter int N_PAIRS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IR_vld,
  input  logic             clr_ovr,
  output logic             clr_accum,
  output logic             en_accum,
  output logic [SEL_W-1:0] sel,
  output logic             sub,
  output logic             busy,
  output logic             err_vld,
  output logic             ovr,
  output logic [1:0]       dbg_state_o
);

  localparam logic [SEL_W-1:0] LAST_SEL = last_sel(N_PAIRS);

  ec_state_t        state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] sel_inc;
  logic             pend_q, pend_d;
  logic             ovr_q, ovr_d;
  logic             ovr_set;
  logic             clr_q, clr_d;
  logic             en_q, en_d;
  logic             sub_q, sub_d;
  logic             busy_q, busy_d;
  logic             vld_q, vld_d;

  assign sel_inc = sel_q + {{(SEL_W-1){1'b0}}, 1'b1};

  // Next-state logic: phase sequencing, operand stepping, start queueing.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pend_d  = pend_q;
    ovr_set = 1'b0;
    clr_d   = 1'b0;
    en_d    = 1'b0;
    sub_d   = 1'b0;
    busy_d  = busy_q;
    vld_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (IR_vld) begin
          state_d = CLR;
          clr_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      CLR: begin
        state_d = ACCUM;
        sel_d   = '0;
        en_d    = 1'b1;
        busy_d  = 1'b1;
        if (IR_vld) begin
          if (pend_q) ovr_set = 1'b1;
          else        pend_d  = 1'b1;
        end
      end
      ACCUM: begin
        busy_d = 1'b1;
        if (sel_q == LAST_SEL) begin
          // sel keeps its last value through DONE
          state_d = DONE;
          vld_d   = 1'b1;
        end else begin
          sel_d = sel_inc;
          en_d  = 1'b1;
          sub_d = sel_inc[0];
        end
        if (IR_vld) begin
          if (pend_q) ovr_set = 1'b1;
          else        pend_d  = 1'b1;
        end
      end
      DONE: begin
        // A request arriving in DONE restarts immediately, like a queued one.
        if (pend_q || IR_vld) begin
          state_d = CLR;
          clr_d   = 1'b1;
          busy_d  = 1'b1;
          pend_d  = 1'b0;
          if (pend_q && IR_vld) ovr_set = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        pend_d  = 1'b0;
      end
    endcase

    // Setting wins over clearing in the same cycle.
    if (ovr_set)      ovr_d = 1'b1;
    else if (clr_ovr) ovr_d = 1'b0;
    else              ovr_d = ovr_q;
  end

  // State, counter, queue flag and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      clr_q   <= 1'b0;
      en_q    <= 1'b0;
      sub_q   <= 1'b0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      clr_q   <= clr_d;
      en_q    <= en_d;
      sub_q   <= sub_d;
      busy_q  <= busy_d;
      vld_q   <= vld_d;
    end
  end

  assign clr_accum   = clr_q;
  assign en_accum    = en_q;
  assign sel         = sel_q;
  assign sub         = sub_q;
  assign busy        = busy_q;
  assign err_vld     = vld_q;
  assign ovr         = ovr_q;
  assign dbg_state_o = state_q;

endmodule
